// File: rtl/miter_seq_lockstep_checker_pkg.sv
// Shared types and helpers for the lockstep miter checker.
package miter_chk_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  // Saturating add; callers pass maxv = 2**CNT_W-1 and truncate the result.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] maxv);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, maxv}) ? maxv : s[31:0];
  endfunction

endpackage

// File: rtl/miter_seq_lockstep_checker_log_fifo.sv
// Mismatch-log FIFO; head is read straight from the register array, zeroed when empty.
module miter_log_fifo #(
  parameter int DEPTH = 8,
  parameter int E_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           push,
  input  logic [E_W-1:0] din,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output logic [E_W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [E_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wp, r_rp;
  logic [AW:0]    r_cnt;
  logic           w_push, w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = push && (!full || w_pop);
  assign dout   = empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

endmodule

// File: rtl/miter_seq_lockstep_checker.sv
// Two-stage lockstep gold/gate comparator with masked diff, counters and mismatch log.
module miter_seq_lockstep_checker
  import miter_chk_pkg::*;
#(
  parameter int WIDTH  = 128,
  parameter int LANES  = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int SETTLE = 2,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   in_valid,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*WIDTH-1:0] gold,
  input  logic [LANES*WIDTH-1:0] gate,
  input  logic [LANES*WIDTH-1:0] xmask,
  output logic                   busy,
  output logic                   fail,
  output logic [CNT_W-1:0]       cmp_cnt,
  output logic [CNT_W-1:0]       mis_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   log_valid,
  input  logic                   log_ready,
  output logic [LW-1:0]          log_lane,
  output logic [CNT_W-1:0]       log_cycle,
  output logic [WIDTH-1:0]       log_diff
);
  localparam int          ST_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [31:0] CMAX = 32'((64'd1 << CNT_W) - 64'd1);

  typedef struct packed {
    logic [LW-1:0]    lane;
    logic [CNT_W-1:0] cycle;
    logic [WIDTH-1:0] diff;
  } log_entry_t;

  state_t                        r_state, w_next;
  logic [ST_W-1:0]               r_settle;
  logic                          w_check;
  logic [LANES-1:0][WIDTH-1:0]   w_diff, r_s1_diff;
  logic [LANES-1:0]              w_hit, r_s1_hit;
  logic                          r_s1_vld;
  logic [CNT_W-1:0]              r_s1_stamp, r_cmp, r_mis, r_drop;
  logic                          r_fail;
  logic [31:0]                   w_pop_cnt, w_drop_add;
  logic [LW-1:0]                 w_lo_lane;
  logic                          w_any, w_full, w_empty, w_log_pop, w_push_ok;
  log_entry_t                    w_push_ent, w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
    end else begin
      r_state <= w_next;
      if (arm)
        r_settle <= ST_W'(SETTLE);
      else if (r_state == ST_SETTLE && in_valid && !stop)
        r_settle <= r_settle - 1'b1;
    end
  end

  // arm beats stop; the SETTLE exit sample itself is not checked
  always_comb begin
    w_next = r_state;
    if (arm)
      w_next = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
    else if (stop)
      w_next = ST_DONE;
    else if (r_state == ST_SETTLE && in_valid && r_settle <= ST_W'(1))
      w_next = ST_CHECK;
  end

  always_comb begin
    busy    = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    w_check = (r_state == ST_CHECK) && in_valid && !arm && !stop;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_diff[i] = (gold[i*WIDTH +: WIDTH] ^ gate[i*WIDTH +: WIDTH]) & ~xmask[i*WIDTH +: WIDTH];
      w_hit[i]  = (|w_diff[i]) && lane_en[i];
    end
  end

  // Descending scan leaves the lowest hit lane in w_lo_lane.
  always_comb begin
    w_pop_cnt = '0;
    w_lo_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      w_pop_cnt = w_pop_cnt + 32'(r_s1_hit[i]);
      if (r_s1_hit[i]) w_lo_lane = LW'(i);
    end
  end

  assign w_any      = r_s1_vld && (|r_s1_hit);
  assign w_log_pop  = log_valid && log_ready;
  assign w_push_ok  = w_any && (!w_full || w_log_pop);
  assign w_drop_add = r_s1_vld ? (w_pop_cnt - 32'(w_push_ok)) : 32'd0;
  assign w_push_ent = '{lane: w_lo_lane, cycle: r_s1_stamp, diff: r_s1_diff[w_lo_lane]};

  always_ff @(posedge clk) begin
    if (rst || arm) begin
      r_s1_vld   <= 1'b0;
      r_s1_diff  <= '0;
      r_s1_hit   <= '0;
      r_s1_stamp <= '0;
      r_cmp      <= '0;
      r_mis      <= '0;
      r_drop     <= '0;
      r_fail     <= 1'b0;
    end else begin
      r_s1_vld <= w_check;
      if (w_check) begin
        r_s1_diff  <= w_diff;
        r_s1_hit   <= w_hit;
        r_s1_stamp <= r_cmp;
        r_cmp      <= CNT_W'(sat_add(32'(r_cmp), 32'd1, CMAX));
      end
      if (r_s1_vld) begin
        r_mis  <= CNT_W'(sat_add(32'(r_mis), w_pop_cnt, CMAX));
        r_drop <= CNT_W'(sat_add(32'(r_drop), w_drop_add, CMAX));
        if (w_any) r_fail <= 1'b1;
      end
    end
  end

  miter_log_fifo #(.DEPTH(DEPTH), .E_W($bits(log_entry_t))) u_log (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .push  (w_push_ok),
    .din   (w_push_ent),
    .pop   (log_ready),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_head)
  );

  assign fail      = r_fail;
  assign cmp_cnt   = r_cmp;
  assign mis_cnt   = r_mis;
  assign drop_cnt  = r_drop;
  assign log_valid = !w_empty;
  assign log_lane  = w_head.lane;
  assign log_cycle = w_head.cycle;
  assign log_diff  = w_head.diff;

endmodule
